// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and buffers them in a small FIFO.
// Each word leaves the FIFO with a sequential instruction-memory byte address.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] immediate,
    input  logic [25:0] jal,
    input  logic [31:0] raw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic [15:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 1;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    logic [31:0]   r_addr;
    logic [15:0]   r_count;

    logic [31:0]   w_packed;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_transfer;

    always_comb begin
        w_packed = raw;
        case (fmt)
            FMT_R:   w_packed = {op, rs, rt, rd, shamt, func};
            FMT_I:   w_packed = {op, rs, rt, immediate};
            FMT_J:   w_packed = {op, jal};
            default: w_packed = raw;
        endcase
    end

    // in_ready is built only from registered occupancy so it never depends on out_ready.
    assign w_full     = (r_occ == OW'(DEPTH));
    assign w_empty    = (r_occ == '0);
    assign in_ready   = !w_full && !reset;
    assign out_valid  = !w_empty;
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_transfer = out_valid && out_ready && !clear;

    assign out_instr  = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    assign out_addr   = r_addr;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_addr   <= BASE_ADDR;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_transfer) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_addr   <= r_addr + 32'd4;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
            case ({w_accept, w_transfer})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] jal;
        logic [31:0] raw;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic [31:0] expected;
    } vector_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [1:0]  fmt = '0;
    logic [5:0]  op = '0;
    logic [5:0]  func = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] immediate = '0;
    logic [25:0] jal = '0;
    logic [31:0] raw = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outInstr;
    logic [31:0] outAddr;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(inValid), .in_ready(inReady),
        .fmt(fmt), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .immediate(immediate), .jal(jal), .raw(raw),
        .out_valid(outValid), .out_ready(outReady),
        .out_instr(outInstr), .out_addr(outAddr), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input fields_t f, input logic valid);
        fmt = f.fmt; op = f.op; func = f.func; rs = f.rs; rt = f.rt; rd = f.rd;
        shamt = f.shamt; immediate = f.imm; jal = f.jal; raw = f.raw;
        inValid = valid;
    endtask

    task automatic doReset();
        reset = 1'b1; clear = 1'b0; inValid = 1'b0; outReady = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
    endtask

    // Field weights straight from the bit layout of each format
    function automatic logic [31:0] packModel(input fields_t f);
        longint w;
        case (f.fmt)
            2'd0: w = longint'(f.op) * 64'd67108864 + longint'(f.rs) * 64'd2097152
                    + longint'(f.rt) * 64'd65536 + longint'(f.rd) * 64'd2048
                    + longint'(f.shamt) * 64'd64 + longint'(f.func);
            2'd1: w = longint'(f.op) * 64'd67108864 + longint'(f.rs) * 64'd2097152
                    + longint'(f.rt) * 64'd65536 + longint'(f.imm);
            2'd2: w = longint'(f.op) * 64'd67108864 + longint'(f.jal);
            default: w = longint'(f.raw);
        endcase
        return w[31:0];
    endfunction

    function automatic fields_t mkRaw(input logic [31:0] v);
        fields_t f;
        f = '{fmt: 2'd3, op: 6'h3F, func: 6'h3F, rs: 5'h1F, rt: 5'h1F, rd: 5'h1F,
              shamt: 5'h1F, imm: 16'hFFFF, jal: 26'h3FF_FFFF, raw: v};
        return f;
    endfunction

    function automatic fields_t randFields();
        fields_t f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = $urandom; b = $urandom; c = $urandom;
        f.fmt = a[1:0]; f.op = a[7:2]; f.func = a[13:8]; f.rs = a[18:14];
        f.rt = a[23:19]; f.rd = a[28:24]; f.shamt = b[4:0]; f.imm = b[20:5];
        f.jal = c[25:0]; f.raw = $urandom;
        return f;
    endfunction

    vector_t vectors[8];
    logic [31:0] modelQ[$];
    logic [31:0] modelAddr;
    logic [15:0] modelCount;

    initial begin
        fields_t f;
        fields_t f2;

        vectors[0] = '{'{2'd0, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0}, 32'h0022_1821};
        vectors[1] = '{'{2'd1, 6'h0D, 6'h3F, 5'd0, 5'd1, 5'd31, 5'd31, 16'h1234, 26'h0, 32'h0}, 32'h3401_1234};
        vectors[2] = '{'{2'd2, 6'h03, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h000_0C03, 32'h0}, 32'h0C00_0C03};
        vectors[3] = '{'{2'd1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h0}, 32'h8FA8_0004};
        vectors[4] = '{'{2'd3, 6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0, 32'hFFFF_FFFF}, 32'hFFFF_FFFF};
        vectors[5] = '{'{2'd0, 6'h00, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 16'hABCD, 26'h0, 32'h0}, 32'h0002_1900};
        vectors[6] = '{'{2'd2, 6'h02, 6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 32'h0}, 32'h0BFF_FFFF};
        vectors[7] = '{'{2'd3, 6'h01, 6'h01, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h1234_5678}, 32'h1234_5678};

        // Reset state, including in_ready low while reset is held
        reset = 1'b1;
        #1;
        checkOutput("in_ready_during_reset", 32'(inReady), 32'd0);
        cycle();
        cycle();
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_instr", outInstr, 32'h0);
        checkOutput("reset_out_addr", outAddr, BASE);
        checkOutput("reset_count", 32'(count), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", 32'(inReady), 32'd1);

        // Vector table: one word at a time, 1-cycle latency, sequential addresses
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].f, 1'b1);
            outReady = 1'b1;
            cycle();
            inValid = 1'b0;
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("vec%0d_instr", i), outInstr, vectors[i].expected);
            checkOutput($sformatf("vec%0d_addr", i), outAddr, BASE + 32'(4 * i));
            cycle();
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(i + 1));
        end

        // I then J back to back
        doReset();
        outReady = 1'b1;
        applyStimulus(vectors[1].f, 1'b1);
        cycle();
        checkOutput("bb_I_instr", outInstr, 32'h3401_1234);
        checkOutput("bb_I_addr", outAddr, 32'h3000);
        applyStimulus(vectors[2].f, 1'b1);
        cycle();
        inValid = 1'b0;
        checkOutput("bb_J_instr", outInstr, 32'h0C00_0C03);
        checkOutput("bb_J_addr", outAddr, 32'h3004);
        cycle();
        checkOutput("bb_count", 32'(count), 32'd2);
        checkOutput("bb_drained", 32'(outValid), 32'd0);

        // Fill with out_ready low, fifth word held, then drain in order
        doReset();
        applyStimulus(vectors[3].f, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkOutput($sformatf("fill%0d_in_ready", i), 32'(inReady), (i < 3) ? 32'd1 : 32'd0);
            applyStimulus(mkRaw(32'h1111_1111 * 32'(i + 1)), 1'b1);
        end
        cycle();
        checkOutput("full_head_held", outInstr, 32'h8FA8_0004);
        checkOutput("full_in_ready", 32'(inReady), 32'd0);
        checkOutput("full_head_addr", outAddr, 32'h3000);
        outReady = 1'b1;
        cycle();
        checkOutput("full_pop_in_ready", 32'(inReady), 32'd1);
        checkOutput("drain1_instr", outInstr, 32'h1111_1111);
        checkOutput("drain1_addr", outAddr, 32'h3004);
        cycle();
        inValid = 1'b0;
        checkOutput("drain2_instr", outInstr, 32'h2222_2222);
        checkOutput("drain2_addr", outAddr, 32'h3008);
        cycle();
        checkOutput("drain3_instr", outInstr, 32'h3333_3333);
        checkOutput("drain3_addr", outAddr, 32'h300C);
        cycle();
        checkOutput("drain4_instr", outInstr, 32'h4444_4444);
        checkOutput("drain4_addr", outAddr, 32'h3010);
        cycle();
        checkOutput("drain_empty", 32'(outValid), 32'd0);
        checkOutput("drain_count", 32'(count), 32'd5);

        // Clear with two words buffered and a concurrent accept
        doReset();
        applyStimulus(mkRaw(32'hAAAA_0001), 1'b1);
        cycle();
        applyStimulus(mkRaw(32'hAAAA_0002), 1'b1);
        cycle();
        applyStimulus(mkRaw(32'hAAAA_0003), 1'b1);
        clear = 1'b1;
        outReady = 1'b1;
        cycle();
        clear = 1'b0;
        inValid = 1'b0;
        checkOutput("clear_out_valid", 32'(outValid), 32'd0);
        checkOutput("clear_addr", outAddr, BASE);
        checkOutput("clear_count", 32'(count), 32'd0);
        checkOutput("clear_instr", outInstr, 32'h0);
        applyStimulus(mkRaw(32'hBEEF_0001), 1'b1);
        cycle();
        inValid = 1'b0;
        checkOutput("post_clear_instr", outInstr, 32'hBEEF_0001);
        checkOutput("post_clear_addr", outAddr, 32'h3000);
        cycle();
        checkOutput("post_clear_count", 32'(count), 32'd1);

        // Randomized run against the queue model
        doReset();
        modelQ.delete();
        modelAddr = BASE;
        modelCount = 16'd0;
        for (int n = 0; n < 600; n++) begin
            logic doPop;
            logic doPush;
            f2 = randFields();
            applyStimulus(f2, ($urandom % 4) != 0);
            outReady = ($urandom % 3) != 0;
            clear = ($urandom % 50) == 0;
            #1;
            checkOutput("rnd_in_ready", 32'(inReady), (modelQ.size() < DEPTH) ? 32'd1 : 32'd0);
            checkOutput("rnd_out_valid", 32'(outValid), (modelQ.size() != 0) ? 32'd1 : 32'd0);
            checkOutput("rnd_out_instr", outInstr, (modelQ.size() != 0) ? modelQ[0] : 32'h0);
            checkOutput("rnd_out_addr", outAddr, modelAddr);
            checkOutput("rnd_count", 32'(count), 32'(modelCount));
            if (clear) begin
                modelQ.delete();
                modelAddr = BASE;
                modelCount = 16'd0;
            end else begin
                doPop = (modelQ.size() != 0) && outReady;
                doPush = inValid && (modelQ.size() < DEPTH);
                if (doPop) begin
                    void'(modelQ.pop_front());
                    modelAddr = modelAddr + 32'd4;
                    if (modelCount != 16'hFFFF) modelCount = modelCount + 16'd1;
                end
                if (doPush) modelQ.push_back(packModel(f2));
            end
            cycle();
        end
        clear = 1'b0;

        // Stream continuously until count saturates
        doReset();
        f = mkRaw(32'h0);
        applyStimulus(f, 1'b1);
        outReady = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            cycle();
        end
        checkOutput("sat_before", 32'(count), 32'h0000_FFFE);
        cycle();
        checkOutput("sat_reached", 32'(count), 32'h0000_FFFF);
        cycle();
        cycle();
        cycle();
        checkOutput("sat_held", 32'(count), 32'h0000_FFFF);
        checkOutput("sat_addr", outAddr, BASE + 32'(4 * 65538));
        inValid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the field-level instruction decoder: packs MIPS opcode/function/register/immediate/jump fields into 32-bit instruction words.
- Buffers packed words in a small FIFO.
- Streams them out with sequential instruction-memory addresses starting at the text base.
- Used by the test/boot loader path to fill IM without a host-side assembler.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_3000, address assigned to the first emitted word after reset/clear

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous soft clear: flush FIFO, rewind address, zero count
in_valid  input  1  field set presented
in_ready  output  1  encoder can accept a field set
fmt  input  2  00=R, 01=I, 10=J, 11=RAW
op  input  6  opcode
func  input  6  R-type function
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register
shamt  input  5  shift amount
immediate  input  16  I-type immediate
jal  input  26  J-type index
raw  input  32  word passed through when fmt=RAW
out_valid  output  1  packed word available
out_ready  input  1  consumer (IM write port) accepts word
out_instr  output  32  packed instruction at FIFO head
out_addr  output  32  IM byte address for out_instr
count  output  16  words emitted since reset/clear, saturating

Behaviour:
- Packing is combinational at the input and registered into the FIFO on accept:
  - R: {op,rs,rt,rd,shamt,func}
  - I: {op,rs,rt,immediate}
  - J: {op,jal}
  - RAW: raw
- Fields unused by the selected format are ignored.
- Accept = in_valid & in_ready.
- Transfer = out_valid & out_ready.
- in_ready = !full & !reset. It is derived only from registered occupancy, with no combinational path from out_ready. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = !empty. out_instr = head entry. Both hold stable while out_valid & !out_ready.
- Latency: a word accepted at edge N drives out_valid=1 from after edge N (1 cycle) if the FIFO was empty.
- Simultaneous accept and transfer with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
- On each transfer:
  - out_addr += 4 (32-bit, wraps modulo 2^32).
  - count += 1, saturating at 16'hFFFF.
- FIFO: circular buffer with read/write pointers plus an occupancy counter (0..DEPTH); pointers wrap at DEPTH.
- Reset (and clear, same cycle effects):
  - FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0.
  - in_ready=0 during reset cycle, 1 the cycle after.
- Reset or clear mid-stream discards all buffered words; an accept or transfer in that same cycle is ignored.
- Reset has priority over clear; clear has priority over accept/transfer.

Test Plan:
- Reset, then R: op=0, rs=1, rt=2, rd=3, shamt=0, func=6'h21, out_ready=1 -> next cycle out_valid=1, out_instr=32'h0022_1821, out_addr=32'h3000; after transfer count=1.
- I then J back-to-back, out_ready=1:
  - I: op=6'h0D, rs=0, rt=1, imm=16'h1234 -> 32'h3401_1234 @ 32'h3000.
  - J: op=6'h03, jal=26'h000_0C03 -> 32'h0C00_0C03 @ 32'h3004.
  - count=2.
- out_ready=0, push 5 words (lw op=6'h23, rs=29, rt=8, imm=4 -> 32'h8FA8_0004 as first):
  - in_ready drops after the 4th accept; 5th held.
  - out_instr stays 32'h8FA8_0004.
  - Raise out_ready -> 5 words emerge in order at 3000, 3004, 3008, 300C, 3010.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push does not; in_ready=1 next cycle.
- With 2 words buffered, assert clear with in_valid=1 -> FIFO empty, out_valid=0, next word emitted at 32'h3000, count restarts at 1.
- RAW fmt, raw=32'hFFFF_FFFF with R fields nonzero -> out_instr=32'hFFFF_FFFF.
- Preload count near saturation by streaming: count holds 16'hFFFF after further transfers.
